// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_mmio: MMIO byte sink with a TX FIFO and an 8N1 serializer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_wr,
  input  logic [7:0]  ip_wr_data,
  input  logic        ip_rd,
  output logic [31:0] op_status,
  output logic        op_tx
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  logic [1:0]          r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_tx;

  logic w_baud_done;
  logic w_pop;
  logic w_push;
  logic w_tx_ready;
  logic w_tx_idle;

  assign w_baud_done = (r_baud == c_BAUD_LAST);
  // A pop happens when the serializer is ready to start a frame: from idle, or at the
  // final stop-bit cycle so the next start bit follows with no gap.
  assign w_pop  = (r_count != '0) &&
                  ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_done));
  assign w_push = ip_wr && ((r_count != c_FULL) || w_pop);

  assign w_tx_ready = (r_count != c_FULL);
  assign w_tx_idle  = (r_state == c_IDLE) && (r_count == '0);
  assign op_status  = {29'b0, r_overflow, w_tx_idle, w_tx_ready};
  assign op_tx      = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ip_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write outranks a same-cycle status read.
      if (ip_wr && !w_push) begin
        r_overflow <= 1'b1;
      end else if (ip_rd) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= c_START;
          end
        end
        c_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= c_DATA;
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end
        c_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= c_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end
        c_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_tx    <= 1'b0;
              r_state <= c_START;
            end else begin
              r_state <= c_IDLE;
            end
          end else begin
            r_baud <= r_baud + c_BAUD_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
